// File: rtl/cv32e40p_wb_port_arbiter.sv
// cv32e40p_wb_port_arbiter
//
// Shares the single ALU/MULT/CSR register-file write port between EX-stage
// results and X-interface (coprocessor) results. X results are buffered in a
// small FIFO. EX normally has priority. A FIFO that becomes full, or that has
// waited STARVE_LIMIT cycles, forces a DRAIN phase in which EX is stalled.
//
// Optional feature: define WB_ARB_BYPASS_EN to write an X result in the same
// cycle it arrives. This happens only when the FIFO is empty and EX is idle.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   ex_we_i/ex_waddr_i/ex_wdata_i  EX write request
//   ex_stall_o                  EX write not granted this cycle (EX holds)
//   x_valid_i/x_ready_o         X result handshake (valid & ready = push)
//   x_rd_i/x_data_i             X destination register / data
//   wr_we_o/wr_waddr_o/wr_wdata_o  register-file write port
//   x_pending_o                 bit r set while a buffered entry targets x r
module cv32e40p_wb_port_arbiter #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_we_i,
    input  logic [5:0]  ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    output logic        ex_stall_o,
    input  logic        x_valid_i,
    output logic        x_ready_o,
    input  logic [4:0]  x_rd_i,
    input  logic [31:0] x_data_i,
    output logic        wr_we_o,
    output logic [5:0]  wr_waddr_o,
    output logic [31:0] wr_wdata_o,
    output logic [31:0] x_pending_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    typedef enum logic {
        EX_PRIO,
        DRAIN
    } state_t;

    state_t         state;
    logic [PW-1:0]  wptr, rptr;
    logic [CW-1:0]  count, count_next;
    logic [SW-1:0]  starve_cnt, starve_next;
    logic [4:0]     fifo_rd   [DEPTH];
    logic [31:0]    fifo_data [DEPTH];
    logic [DEPTH-1:0] ent_valid;

    logic push, pop, bypass;

    // Handshake, pop/push decisions and the write-port mux
    always_comb begin
        x_ready_o = rst_n && (count != DEPTH_C);

        bypass = 1'b0;
`ifdef WB_ARB_BYPASS_EN
        bypass = rst_n && (state == EX_PRIO) && (count == '0) && !ex_we_i &&
                 x_valid_i && (x_rd_i != '0);
`endif

        pop  = rst_n && (count != '0) && ((state == DRAIN) || !ex_we_i);
        // rd==0 completes the handshake but is never stored
        push = x_ready_o && x_valid_i && (x_rd_i != '0) && !bypass;

        wr_we_o    = 1'b0;
        wr_waddr_o = '0;
        wr_wdata_o = '0;
        ex_stall_o = 1'b0;
        if (rst_n) begin
            if ((state == EX_PRIO) && ex_we_i) begin
                wr_we_o    = 1'b1;
                wr_waddr_o = ex_waddr_i;
                wr_wdata_o = ex_wdata_i;
            end else if (pop) begin
                wr_we_o    = 1'b1;
                wr_waddr_o = {1'b0, fifo_rd[rptr]};
                wr_wdata_o = fifo_data[rptr];
            end else if (bypass) begin
                wr_we_o    = 1'b1;
                wr_waddr_o = {1'b0, x_rd_i};
                wr_wdata_o = x_data_i;
            end
            ex_stall_o = (state == DRAIN) && ex_we_i;
        end

        count_next = count + CW'(push) - CW'(pop);

        if ((count == '0) || pop) begin
            starve_next = '0;
        end else if (starve_cnt == STARVE_C) begin
            starve_next = starve_cnt;
        end else begin
            starve_next = starve_cnt + 1'b1;
        end
    end

    // The pending map is taken from stored entries only.
    // It therefore lags push and pop by one cycle.
    always_comb begin
        x_pending_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                x_pending_o[fifo_rd[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EX_PRIO;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            starve_cnt <= '0;
            ent_valid  <= '0;
        end else begin
            count      <= count_next;
            starve_cnt <= starve_next;

            // A push and a pop never hit the same slot.
            // Push needs the FIFO not full and pop needs it not empty.
            if (push) begin
                ent_valid[wptr] <= 1'b1;
                wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
            end
            if (pop) begin
                ent_valid[rptr] <= 1'b0;
                rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
            end

            case (state)
                EX_PRIO: if ((count_next == DEPTH_C) || (starve_next == STARVE_C)) state <= DRAIN;
                DRAIN:   if (count_next == '0) state <= EX_PRIO;
                default: state <= EX_PRIO;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wptr]   <= x_rd_i;
            fifo_data[wptr] <= x_data_i;
        end
    end

endmodule
